// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register slave.
//   resp_t     : AXI response encoding driven on BRESP/RRESP.
//   wr_state_t : write-channel FSM state (WR_* constants).
//   rd_state_t : read-channel FSM state (RD_* constants).
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t WR_IDLE      = 2'd0;
  localparam wr_state_t WR_HAVE_ADDR = 2'd1;
  localparam wr_state_t WR_HAVE_DATA = 2'd2;
  localparam wr_state_t WR_RESP      = 2'd3;

  typedef logic [0:0] rd_state_t;
  localparam rd_state_t RD_IDLE = 1'b0;
  localparam rd_state_t RD_RESP = 1'b1;

endpackage

// File: rtl/axi4_lite_reg_slave_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   modport master : drives addresses, data, strobes, valids and response readies.
//   modport slave  : drives address/data readies and the B/R responses.
interface axi4_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import axi4_lite_pkg::*;

  localparam int BYTES = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BYTES-1:0]      wstrb;
  logic                  wvalid;
  logic                  wready;
  resp_t                 bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  resp_t                 rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4_lite_reg_slave_reg_bank.sv
// Register storage with per-byte write strobes.
//   aclk, aresetn : clock, async active-low reset (clears every register)
//   we            : commit a write this edge
//   widx          : register index to write
//   wdata, wstrb  : write data and byte enables; unstrobed lanes keep their value
//   regs_o        : all registers flattened, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
module axi4_lite_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int BYTES      = DATA_WIDTH / 8,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           we,
  input  logic [IDX_W-1:0]               widx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [BYTES-1:0]               wstrb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // NOTE: this storage is reset because the all-zero register state is visible
  // on regs_o and to reads straight after reset; a plain RAM would not be.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) regs[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS memory-mapped registers.
//   aclk, aresetn : clock, async active-low reset
//   axi           : AXI4-Lite slave modport (AW/W/B write path, AR/R read path)
//   regs_o        : all registers flattened, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// Write and read FSMs run independently; AW and W may arrive in either order.
module axi4_lite_reg_slave
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  axi4_lite_if.slave                     axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int IDX_LSB = $clog2(BYTES);
  localparam int IDX_W   = $clog2(NUM_REGS);

  // In range when no address bit above the register index is set,
  // i.e. addr < NUM_REGS*BYTES.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> (IDX_LSB + IDX_W)) == '0;
  endfunction

  // ---------------- write path ----------------
  wr_state_t             wr_state;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [BYTES-1:0]      w_strb_q;
  resp_t                 bresp_q;

  logic                  aw_hs, w_hs, wr_fire, wr_ok;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BYTES-1:0]      wr_strb;

  // Readies are gated by reset so nothing is accepted while it is asserted.
  assign axi.awready = aresetn && (wr_state == WR_IDLE || wr_state == WR_HAVE_DATA);
  assign axi.wready  = aresetn && (wr_state == WR_IDLE || wr_state == WR_HAVE_ADDR);
  assign axi.bvalid  = (wr_state == WR_RESP);
  assign axi.bresp   = bresp_q;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;

  // The half that arrived first is taken from its capture register, the
  // completing half straight off the bus, so the write lands on that edge.
  assign wr_addr = (wr_state == WR_HAVE_ADDR) ? aw_addr_q : axi.awaddr;
  assign wr_data = (wr_state == WR_HAVE_DATA) ? w_data_q  : axi.wdata;
  assign wr_strb = (wr_state == WR_HAVE_DATA) ? w_strb_q  : axi.wstrb;
  assign wr_ok   = in_range(wr_addr);
  assign wr_fire = (wr_state == WR_IDLE      && aw_hs && w_hs) ||
                   (wr_state == WR_HAVE_ADDR && w_hs)          ||
                   (wr_state == WR_HAVE_DATA && aw_hs);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state  <= WR_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_addr_q <= axi.awaddr;
      if (w_hs) begin
        w_data_q <= axi.wdata;
        w_strb_q <= axi.wstrb;
      end
      if (wr_fire) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;

      case (wr_state)
        WR_IDLE: begin
          if (aw_hs && w_hs) wr_state <= WR_RESP;
          else if (aw_hs)    wr_state <= WR_HAVE_ADDR;
          else if (w_hs)     wr_state <= WR_HAVE_DATA;
        end
        WR_HAVE_ADDR: if (w_hs)       wr_state <= WR_RESP;
        WR_HAVE_DATA: if (aw_hs)      wr_state <= WR_RESP;
        WR_RESP:      if (axi.bready) wr_state <= WR_IDLE;
        default:                      wr_state <= WR_IDLE;
      endcase
    end
  end

  axi4_lite_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_bank (
    .aclk    (aclk),
    .aresetn (aresetn),
    .we      (wr_fire && wr_ok),
    .widx    (wr_addr[IDX_LSB +: IDX_W]),
    .wdata   (wr_data),
    .wstrb   (wr_strb),
    .regs_o  (regs_o)
  );

  // ---------------- read path ----------------
  rd_state_t             rd_state;
  logic [DATA_WIDTH-1:0] rdata_q;
  resp_t                 rresp_q;
  logic                  ar_hs, rd_ok;
  logic [IDX_W-1:0]      rd_idx;

  assign axi.arready = aresetn && (rd_state == RD_IDLE);
  assign axi.rvalid  = (rd_state == RD_RESP);
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  assign ar_hs  = axi.arvalid && axi.arready;
  assign rd_ok  = in_range(axi.araddr);
  assign rd_idx = axi.araddr[IDX_LSB +: IDX_W];

  // Data is sampled from the pre-edge registers, so a read racing a write to
  // the same register returns the old value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= RD_IDLE;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_state <= RD_RESP;
            rdata_q  <= rd_ok ? regs_o[rd_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
            rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        RD_RESP: if (axi.rready) rd_state <= RD_IDLE;
        default:                 rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Self-checking bench for axi4_lite_reg_slave: directed scenarios followed by
// randomized traffic; expected B/R responses are queued when stimulus is issued
// and a negedge monitor pops and compares them at each response handshake.
module tb_axi4_lite_reg_slave;
  import axi4_lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int NB = DW / 8;

  logic aclk = 1'b0;
  logic aresetn;
  logic [NR*DW-1:0] regs_o;

  always #5 aclk = ~aclk;

  axi4_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axi     (bus.slave),
    .regs_o  (regs_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic [DW-1:0] data;
    resp_t         resp;
  } rexp_t;

  logic [DW-1:0] model [NR];
  resp_t b_q[$];
  rexp_t r_q[$];

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
    if (a < NR * NB) begin
      for (int b = 0; b < NB; b++)
        if (s[b]) model[a / NB][8*b +: 8] = d[8*b +: 8];
      b_q.push_back(RESP_OKAY);
    end else begin
      b_q.push_back(RESP_SLVERR);
    end
  endtask

  task automatic model_read(input logic [AW-1:0] a);
    rexp_t e;
    if (a < NR * NB) begin
      e.data = model[a / NB];
      e.resp = RESP_OKAY;
    end else begin
      e.data = '0;
      e.resp = RESP_SLVERR;
    end
    r_q.push_back(e);
  endtask

  task automatic check_regs();
    for (int i = 0; i < NR; i++)
      check($sformatf("regs_o[%0d]", i), regs_o[i*DW +: DW], model[i]);
  endtask

  // ---------------- monitor ----------------
  logic          b_hold, r_hold;
  resp_t         prev_bresp, prev_rresp;
  logic [DW-1:0] prev_rdata;

  always @(negedge aclk) begin
    if (!aresetn) begin
      b_hold = 1'b0;
      r_hold = 1'b0;
    end else begin
      if (b_hold && bus.bvalid) check("bresp_stable", bus.bresp, prev_bresp);
      if (r_hold && bus.rvalid) begin
        check("rdata_stable", bus.rdata, prev_rdata);
        check("rresp_stable", bus.rresp, prev_rresp);
      end
      if (bus.bvalid && bus.bready) begin
        if (b_q.size() == 0) check("b_unexpected", 1, 0);
        else check("bresp", bus.bresp, b_q.pop_front());
      end
      if (bus.rvalid && bus.rready) begin
        if (r_q.size() == 0) check("r_unexpected", 1, 0);
        else begin
          rexp_t e;
          e = r_q.pop_front();
          check("rdata", bus.rdata, e.data);
          check("rresp", bus.rresp, e.resp);
        end
      end
      b_hold     = bus.bvalid && !bus.bready;
      r_hold     = bus.rvalid && !bus.rready;
      prev_bresp = bus.bresp;
      prev_rresp = bus.rresp;
      prev_rdata = bus.rdata;
    end
  end

  // ---------------- bus drivers (enter and leave 1 time unit after a rising edge) ----------------
  task automatic send_aw(input logic [AW-1:0] a, input int delay);
    int n;
    repeat (delay) begin @(posedge aclk); #1; end
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!bus.awready && n < 50) begin @(negedge aclk); n++; end
    if (!bus.awready) check("awready_timeout", 0, 1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [NB-1:0] s, input int delay);
    int n;
    repeat (delay) begin @(posedge aclk); #1; end
    bus.wdata  = d;
    bus.wstrb  = s;
    bus.wvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!bus.wready && n < 50) begin @(negedge aclk); n++; end
    if (!bus.wready) check("wready_timeout", 0, 1);
    @(posedge aclk); #1;
    bus.wvalid = 1'b0;
  endtask

  // gap > 0: W leads AW by gap cycles; gap < 0: AW leads. bdelay < 0: BREADY high up front.
  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s,
                           input int gap, input int bdelay);
    if (bdelay < 0) bus.bready = 1'b1;
    fork
      send_aw(a, gap > 0 ? gap : 0);
      send_w(d, s, gap < 0 ? -gap : 0);
    join
    @(negedge aclk);
    check("bvalid_latency", bus.bvalid, 1);
    if (bdelay >= 0) begin
      repeat (bdelay) begin
        @(posedge aclk); #1;
        @(negedge aclk);
        check("bvalid_hold", bus.bvalid, 1);
      end
      @(posedge aclk); #1;
      bus.bready = 1'b1;
      @(negedge aclk);
    end
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    @(negedge aclk);
    check("bvalid_clear", bus.bvalid, 0);
    check_regs();
    @(posedge aclk); #1;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input int rdelay);
    int n;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!bus.arready && n < 50) begin @(negedge aclk); n++; end
    if (!bus.arready) check("arready_timeout", 0, 1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    @(negedge aclk);
    check("rvalid_latency", bus.rvalid, 1);
    check("arready_busy", bus.arready, 0);
    repeat (rdelay) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      check("rvalid_hold", bus.rvalid, 1);
      check("arready_held_low", bus.arready, 0);
    end
    @(posedge aclk); #1;
    bus.rready = 1'b1;
    @(negedge aclk);
    @(posedge aclk); #1;
    bus.rready = 1'b0;
    @(negedge aclk);
    check("rvalid_clear", bus.rvalid, 0);
    check("arready_idle", bus.arready, 1);
    @(posedge aclk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, bus.awready, 0);
    check({tag, "_wready"},  bus.wready,  0);
    check({tag, "_arready"}, bus.arready, 0);
    check({tag, "_bvalid"},  bus.bvalid,  0);
    check({tag, "_rvalid"},  bus.rvalid,  0);
    check({tag, "_bresp"},   bus.bresp,   0);
    check({tag, "_rresp"},   bus.rresp,   0);
    check({tag, "_rdata"},   bus.rdata,   0);
    check({tag, "_regs_o"},  (regs_o == '0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] a, a2;
    logic [DW-1:0] d;
    logic [NB-1:0] s;

    aresetn     = 1'b0;
    bus.awaddr  = '0; bus.awvalid = 1'b0;
    bus.wdata   = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0; bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    model_reset();

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("reset");

    // Release and confirm all channels are ready on the very next edge.
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("ready_after_reset_aw", bus.awready, 1);
    check("ready_after_reset_w",  bus.wready,  1);
    check("ready_after_reset_ar", bus.arready, 1);
    @(posedge aclk); #1;

    // AW and W together.
    model_write(32'h08, 32'hDEADBEEF, 4'hF);
    bus_write(32'h08, 32'hDEADBEEF, 4'hF, 0, -1);
    check("reg2_full_write", regs_o[2*DW +: DW], 32'hDEADBEEF);

    // W three cycles ahead of AW with a partial strobe.
    model_write(32'h04, 32'hAAAAAAAA, 4'hF);
    bus_write(32'h04, 32'hAAAAAAAA, 4'hF, 0, 0);
    model_write(32'h04, 32'h12345678, 4'h3);
    bus_write(32'h04, 32'h12345678, 4'h3, 3, 1);
    check("reg1_partial_write", regs_o[1*DW +: DW], 32'hAAAA5678);

    // Read held off by RREADY low for 4 cycles.
    model_read(32'h08);
    bus_read(32'h08, 4);

    // Out-of-range write and read.
    model_write(32'h40, 32'hCAFEF00D, 4'hF);
    bus_write(32'h40, 32'hCAFEF00D, 4'hF, -2, 2);
    model_read(32'h40);
    bus_read(32'h40, 0);

    // Empty strobe, and an unaligned address whose low bits are ignored.
    model_write(32'h0C, 32'hFFFFFFFF, 4'h0);
    bus_write(32'h0C, 32'hFFFFFFFF, 4'h0, 0, 0);
    model_write(32'h0E, 32'h0BADF00D, 4'hC);
    bus_write(32'h0E, 32'h0BADF00D, 4'hC, -1, 0);

    // Read and write of the same register on the same edge returns the old value.
    model_read(32'h08);
    model_write(32'h08, 32'h5555AAAA, 4'hF);
    fork
      bus_read(32'h08, 1);
      bus_write(32'h08, 32'h5555AAAA, 4'hF, 0, -1);
    join

    // Reset while a write is parked in WR_HAVE_ADDR.
    bus.awaddr  = 32'h10;
    bus.awvalid = 1'b1;
    @(negedge aclk);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    @(negedge aclk);
    check("have_addr_wready", bus.wready, 1);
    check("have_addr_awready", bus.awready, 0);
    #2;
    aresetn = 1'b0;
    model_reset();
    bus.wdata  = 32'h77777777;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge aclk); #1;
    bus.wvalid = 1'b0;
    aresetn    = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("no_bvalid_after_reset", bus.bvalid, 0);
    end
    check_regs();
    @(posedge aclk); #1;
    model_write(32'h10, 32'h01020304, 4'hF);
    bus_write(32'h10, 32'h01020304, 4'hF, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      a  = $urandom_range(0, NR * NB + 15);
      a2 = $urandom_range(0, NR * NB + 15);
      d  = $urandom;
      s  = NB'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: begin
          model_write(a, d, s);
          bus_write(a, d, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 4)) - 1);
        end
        1: begin
          model_read(a);
          bus_read(a, $urandom_range(0, 3));
        end
        default: begin
          model_read(a2);
          model_write(a, d, s);
          fork
            bus_read(a2, $urandom_range(0, 3));
            bus_write(a, d, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 4)) - 1);
          join
        end
      endcase
    end

    repeat (2) @(posedge aclk);
    check("b_queue_drained", b_q.size(), 0);
    check("r_queue_drained", r_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_reg_slave.md
AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

Interface
REQ-001 Parameter ADDR_WIDTH, 32, SHALL set AWADDR/ARADDR width.
REQ-002 Parameter DATA_WIDTH, 32, SHALL set data width; legal values 32 or 64; BYTES = DATA_WIDTH/8.
REQ-003 Parameter NUM_REGS, 16, SHALL set register count; power of two, 2..256.
REQ-004 ACLK  in  1  SHALL be the single clock; all logic on rising edge.
REQ-005 ARESETn  in  1  SHALL be the reset: asynchronous assert, active-low, deassert synchronised externally.
REQ-006 AWADDR  in  ADDR_WIDTH  SHALL carry the write byte address.
REQ-007 AWVALID  in  1 / AWREADY  out  1  SHALL form the write-address handshake.
REQ-008 WDATA  in  DATA_WIDTH / WSTRB  in  BYTES  SHALL carry write data and byte enables.
REQ-009 WVALID  in  1 / WREADY  out  1  SHALL form the write-data handshake.
REQ-010 BRESP  out  2 / BVALID  out  1 / BREADY  in  1  SHALL form the write-response channel.
REQ-011 ARADDR  in  ADDR_WIDTH / ARVALID  in  1 / ARREADY  out  1  SHALL form the read-address channel.
REQ-012 RDATA  out  DATA_WIDTH / RRESP  out  2 / RVALID  out  1 / RREADY  in  1  SHALL form the read-data channel.
REQ-013 regs_o  out  NUM_REGS*DATA_WIDTH  SHALL expose all registers, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-014 Index SHALL be addr[log2(BYTES) +: log2(NUM_REGS)]; address >= NUM_REGS*BYTES SHALL be out of range; low log2(BYTES) bits ignored.
REQ-015 Write FSM SHALL have states WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP.
REQ-016 AWREADY SHALL be 1 in WR_IDLE and WR_HAVE_DATA, else 0; WREADY SHALL be 1 in WR_IDLE and WR_HAVE_ADDR, else 0.
REQ-017 WR_IDLE SHALL go to WR_HAVE_ADDR on AW-only handshake, WR_HAVE_DATA on W-only, WR_RESP on both same edge.
REQ-018 WR_HAVE_ADDR/WR_HAVE_DATA SHALL go to WR_RESP on the completing handshake; AW and W order SHALL be arbitrary.
REQ-019 On the edge entering WR_RESP the register SHALL be updated for each byte lane with WSTRB set; lanes with WSTRB clear SHALL keep their value.
REQ-020 In WR_RESP BVALID SHALL be 1; BRESP SHALL be OKAY (2'b00) in range, SLVERR (2'b10) out of range with no register modified.
REQ-021 WR_RESP SHALL return to WR_IDLE on BVALID&&BREADY; BRESP SHALL hold stable while BVALID&&!BREADY.
REQ-022 Read FSM SHALL have states RD_IDLE, RD_RESP; ARREADY SHALL equal (state==RD_IDLE).
REQ-023 AR handshake SHALL move to RD_RESP with RVALID=1 next cycle (latency 1), RDATA=register value before that edge, RRESP=OKAY; out of range SHALL give RDATA=0, RRESP=SLVERR.
REQ-024 RDATA/RRESP SHALL hold stable while RVALID&&!RREADY; RD_RESP SHALL return to RD_IDLE on RVALID&&RREADY.
REQ-025 Read and write channels SHALL run concurrently; read of a register written on the same edge SHALL return the pre-write value.
REQ-026 WSTRB all-zero SHALL complete with BRESP=OKAY and no data change.

Reset
REQ-027 While ARESETn=0: both FSMs SHALL be idle-reset, all READY/VALID outputs 0, BRESP/RRESP/RDATA 0, all registers 0; in-flight transactions SHALL be dropped with no register write.
REQ-028 First handshake SHALL be accepted on the first rising edge after ARESETn deasserts.

Structure
REQ-029 Package axi4_lite_pkg SHALL hold resp_t (OKAY/EXOKAY/SLVERR/DECERR), wr_state_t, rd_state_t.
REQ-030 Storage and strobe merge SHALL live in sub-module axi4_lite_reg_bank; FSMs and decode in the top.

Verification
REQ-031 AW and W same cycle, addr 0x08, data 0xDEADBEEF, WSTRB 0xF -> BVALID next cycle, BRESP=OKAY, reg2=0xDEADBEEF.
REQ-032 W three cycles before AW (addr 0x04, data 0x12345678, WSTRB 0x3) on reg1=0xAAAAAAAA -> reg1=0xAAAA5678.
REQ-033 AR addr 0x08 with RREADY=0 for 4 cycles -> RVALID held, RDATA=0xDEADBEEF stable, ARREADY=0 until accepted.
REQ-034 Write addr 0x40 (NUM_REGS=16) -> BRESP=SLVERR, regs_o unchanged; read 0x40 -> RDATA=0, RRESP=SLVERR.
REQ-035 ARESETn low while in WR_HAVE_ADDR -> all outputs 0, regs_o=0, after release no BVALID and next write completes normally.
